uart_cmd_parser: RTL and testbench

- Byte-level command-frame parser between the UART receiver/transmitter and the CRG register file/run controller.
- Generalises the fixed 128-bit write / run protocol to a parametrised payload width.
- Adds register read-back over UART, an inter-byte timeout, run-while-busy rejection and error reporting.
- Frames: WRITE = 0x10, addr, DATA_BYTES payload bytes LSB-first; READ = 0x20, addr; RUN = 0x40 (single byte).

---
 rtl/crg_uart_pkg.sv | 14 +
 rtl/uart_tx_serializer.sv | 35 +++
 rtl/uart_cmd_parser.sv | 121 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/crg_uart_pkg.sv
// crg_uart_pkg: command bytes, error codes and parser states shared by the UART command path
package crg_uart_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h10;
  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_RUN   = 8'h40;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD     = 3'd1,
    ERR_TIMEOUT = 3'd2,
    ERR_BUSY    = 3'd3,
    ERR_OVERRUN = 3'd4
  } err_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WR, S_RD_REQ, S_RD_LAT, S_TX} state_e;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: parallel-load shift register emitting DATA_BYTES bytes LSB-first over valid/ready
// ports: clk, rst_n (async, active-low); load/din capture a word; tx_data/tx_valid/tx_ready handshake;
// done pulses combinationally on the final accepted byte
module uart_tx_serializer #(
  parameter int DATA_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [8*DATA_BYTES-1:0] din,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    done
);
  localparam int CW = $clog2(DATA_BYTES) + 1;
  logic [8*DATA_BYTES-1:0] sh;
  logic [CW-1:0]           cnt;
  assign tx_data = sh[7:0];
  assign done    = tx_valid && tx_ready && cnt == CW'(DATA_BYTES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh       <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sh       <= din;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      sh       <= sh >> 8;
      cnt      <= cnt + 1'b1;
      tx_valid <= !done;
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses WRITE/READ/RUN byte frames from the UART into register-file and run strobes
// ports: CLK100MHZ, ck_rst_n (async, active-low); rx_data/rx_valid incoming bytes;
// tx_data/tx_valid/tx_ready read-back bytes; reg_addr/reg_wdata/reg_wr_en/reg_rd_en/reg_rdata register port;
// run_busy/run_pulse run control; err_pulse/err_code error reporting
module uart_cmd_parser
  import crg_uart_pkg::*;
#(
  parameter  int DATA_BYTES  = 16,
  parameter  int ADDR_W      = 8,
  parameter  int TIMEOUT_CYC = 100000,
  localparam int DATA_W      = 8 * DATA_BYTES
) (
  input  logic              CLK100MHZ,
  input  logic              ck_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              run_busy,
  output logic              run_pulse,
  output logic              err_pulse,
  output logic [2:0]        err_code
);
  localparam int CW = $clog2(DATA_BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  state_e        state;
  logic          wr;
  logic [CW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic          tx_done;
  logic          rx_drop;
  logic          t_exp;
  assign rx_drop = rx_valid && state inside {S_WR, S_RD_REQ, S_RD_LAT, S_TX};
  assign t_exp   = tcnt == TW'(TIMEOUT_CYC - 1);
  uart_tx_serializer #(.DATA_BYTES(DATA_BYTES)) u_tx (
    .clk      (CLK100MHZ),
    .rst_n    (ck_rst_n),
    .load     (state == S_RD_LAT),
    .din      (reg_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (tx_done)
  );
  // Strobes are raised on the transition into WR/RD_REQ so they appear the cycle after the byte.
  // The overrun check sits after the case so it overrides a same-cycle clear of err_code.
  always_ff @(posedge CLK100MHZ or negedge ck_rst_n)
    if (!ck_rst_n) begin
      state     <= S_IDLE;
      wr        <= 1'b0;
      bcnt      <= '0;
      tcnt      <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      run_pulse <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      run_pulse <= 1'b0;
      err_pulse <= 1'b0;
      tcnt      <= '0;
      case (state)
        S_IDLE: if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            wr    <= rx_data == CMD_WRITE;
            state <= S_ADDR;
          end else if (rx_data == CMD_RUN && !run_busy) begin
            run_pulse <= 1'b1;
            err_code  <= ERR_NONE;
          end else begin
            err_pulse <= 1'b1;
            err_code  <= rx_data == CMD_RUN ? ERR_BUSY : ERR_CMD;
          end
        end
        S_ADDR, S_DATA: if (rx_valid) begin
          if (state == S_ADDR) begin
            reg_addr  <= rx_data[ADDR_W-1:0];
            bcnt      <= '0;
            reg_rd_en <= !wr;
            state     <= wr ? S_DATA : S_RD_REQ;
          end else begin
            reg_wdata <= {rx_data, reg_wdata[DATA_W-1:8]};
            bcnt      <= bcnt + 1'b1;
            if (bcnt == CW'(DATA_BYTES - 1)) begin
              reg_wr_en <= 1'b1;
              state     <= S_WR;
            end
          end
        end else if (t_exp) begin
          err_pulse <= 1'b1;
          err_code  <= ERR_TIMEOUT;
          state     <= S_IDLE;
        end else tcnt <= tcnt + 1'b1;
        S_WR: begin
          err_code <= ERR_NONE;
          state    <= S_IDLE;
        end
        S_RD_REQ: state <= S_RD_LAT;
        S_RD_LAT: state <= S_TX;
        S_TX: if (tx_done) begin
          err_code <= ERR_NONE;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (rx_drop) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_OVERRUN;
      end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;
  import crg_uart_pkg::*;
  localparam int DB = 16;
  localparam int TO = 1000;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [7:0]   reg_addr;
  logic [127:0] reg_wdata;
  logic         reg_wr_en;
  logic         reg_rd_en;
  logic [127:0] reg_rdata = '0;
  logic         run_busy = 1'b0;
  logic         run_pulse;
  logic         err_pulse;
  logic [2:0]   err_code;
  uart_cmd_parser #(.DATA_BYTES(DB), .ADDR_W(8), .TIMEOUT_CYC(TO)) dut (
    .CLK100MHZ (clk),
    .ck_rst_n  (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .run_busy  (run_busy),
    .run_pulse (run_pulse),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int wr_n = 0, rd_n = 0, run_n = 0, err_n = 0, both_n = 0;
  logic [127:0] wr_data = '0;
  logic [7:0]   wr_addr = '0;
  logic [2:0]   err_last = '0;
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_n++;
      wr_data = reg_wdata;
      wr_addr = reg_addr;
    end
    if (reg_rd_en) rd_n++;
    if (run_pulse) run_n++;
    if (err_pulse) begin
      err_n++;
      err_last = err_code;
    end
    if (run_pulse && err_pulse) both_n++;
  end
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_write(input logic [7:0] addr, input logic [127:0] d);
    send(CMD_WRITE);
    send(addr);
    for (int i = 0; i < DB; i++) send(d[8*i +: 8]);
    chk("wr_latency", reg_wr_en, 1'b1);
  endtask
  task automatic do_read(input logic [7:0] addr, input int inj, output logic [127:0] got, output int n);
    logic       pv, pr;
    logic [7:0] pd;
    got = '0;
    n   = 0;
    pv  = 1'b0;
    pr  = 1'b0;
    pd  = '0;
    send(CMD_READ);
    send(addr);
    for (int k = 0; k < 120 && !(n >= DB && !tx_valid); k++) begin
      if (pv && !pr && tx_valid) chk("tx_hold", tx_data, pd);
      rx_data  = 8'h55;
      rx_valid = k == inj;
      tx_ready = ~tx_ready;
      if (tx_valid && tx_ready) begin
        if (n < DB) got[8*n +: 8] = tx_data;
        n++;
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
  endtask
  logic [7:0] wbytes [16] = '{8'hcd, 8'h07, 8'h2c, 8'hd8, 8'hbe, 8'h6f, 8'h9f, 8'h62,
                              8'hac, 8'h4c, 8'h09, 8'hc2, 8'h82, 8'h06, 8'he7, 8'he3};
  initial begin
    int w0, r0, u0, e0, n;
    logic [127:0] got;
    idle(3);
    chk("rst_ctrl", {tx_valid, reg_wr_en, reg_rd_en, run_pulse, err_pulse, err_code}, '0);
    chk("rst_addr_tx", {reg_addr, tx_data}, '0);
    chk("rst_wdata", reg_wdata, '0);
    rst_n = 1'b1;
    idle(2);
    w0 = wr_n;
    send(CMD_WRITE);
    send(8'h10);
    for (int i = 0; i < DB; i++) send(wbytes[i]);
    chk("wr1_latency", reg_wr_en, 1'b1);
    idle(3);
    chk("wr1_count", wr_n - w0, 1);
    chk("wr1_addr", wr_addr, 8'h10);
    chk("wr1_data", wr_data, 128'he3e70682c2094cac629f6fbed82c07cd);
    chk("wr1_hold", reg_wdata, 128'he3e70682c2094cac629f6fbed82c07cd);
    chk("wr1_err", err_code, 3'd0);
    u0 = run_n;
    e0 = err_n;
    send(CMD_RUN);
    idle(2);
    chk("run_ok", run_n - u0, 1);
    chk("run_ok_err", err_n - e0, 0);
    run_busy = 1'b1;
    send(CMD_RUN);
    idle(2);
    run_busy = 1'b0;
    chk("run_busy_run", run_n - u0, 1);
    chk("run_busy_errs", err_n - e0, 1);
    chk("run_busy_code", err_code, 3'd3);
    r0 = rd_n;
    e0 = err_n;
    reg_rdata = 128'd3;
    do_read(8'h13, -1, got, n);
    chk("rd1_nbytes", n, DB);
    chk("rd1_bytes", got, 128'd3);
    chk("rd1_rden", rd_n - r0, 1);
    chk("rd1_addr", reg_addr, 8'h13);
    chk("rd1_err", err_code, 3'd0);
    chk("rd1_errs", err_n - e0, 0);
    chk("rd1_valid_low", tx_valid, 1'b0);
    w0 = wr_n;
    e0 = err_n;
    send(CMD_WRITE);
    send(8'h11);
    for (int i = 0; i < 5; i++) send(8'ha0 + 8'(i));
    idle(TO - 5);
    chk("to_early", err_n - e0, 0);
    idle(15);
    chk("to_errs", err_n - e0, 1);
    chk("to_code", err_code, 3'd2);
    chk("to_no_wr", wr_n - w0, 0);
    do_write(8'h22, 128'hffeeddccbbaa99887766554433221100);
    idle(3);
    chk("to_wr_count", wr_n - w0, 1);
    chk("to_wr_data", wr_data, 128'hffeeddccbbaa99887766554433221100);
    chk("to_wr_addr", wr_addr, 8'h22);
    chk("to_wr_clear", err_code, 3'd0);
    e0 = err_n;
    send(8'h55);
    idle(2);
    chk("unk_errs", err_n - e0, 1);
    chk("unk_code", err_code, 3'd1);
    e0 = err_n;
    reg_rdata = 128'h0123456789abcdeffedcba9876543210;
    do_read(8'h07, 6, got, n);
    chk("ovr_nbytes", n, DB);
    chk("ovr_bytes", got, 128'h0123456789abcdeffedcba9876543210);
    chk("ovr_errs", err_n - e0, 1);
    chk("ovr_code", err_last, 3'd4);
    w0 = wr_n;
    send(CMD_WRITE);
    send(8'h30);
    for (int i = 0; i < 3; i++) send(8'h5a);
    rst_n = 1'b0;
    idle(2);
    chk("mrst_ctrl", {tx_valid, reg_wr_en, reg_rd_en, run_pulse, err_pulse, err_code}, '0);
    chk("mrst_addr", reg_addr, 8'h00);
    chk("mrst_wdata", reg_wdata, '0);
    rst_n = 1'b1;
    idle(2);
    chk("mrst_no_wr", wr_n - w0, 0);
    do_write(8'h44, 128'h0f0e0d0c0b0a09080706050403020100);
    idle(3);
    chk("mrst_wr_count", wr_n - w0, 1);
    chk("mrst_wr_data", wr_data, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("mrst_wr_addr", wr_addr, 8'h44);
    chk("run_err_overlap", both_n, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
